// File: rtl/rd_lane_checker.sv
// Multi-lane running-disparity checker for 8b/10b symbol streams.
// LANES symbols arrive per cycle. Lane 0 is the oldest symbol. Running
// disparity (RD) is chained through the lanes combinationally. Per-lane RD
// and error flags are registered with one cycle of latency. A saturating
// counter accumulates the number of erroneous symbols.
module rd_lane_checker #(
    parameter int WIDTH    = 10,
    parameter int LANES    = 4,
    parameter int ERRCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startin,
    input  logic [LANES*WIDTH-1:0] datain,
    input  logic                   pushin,
    input  logic                   err_clr,
    output logic                   pushout,
    output logic [LANES-1:0]       rd_vec,
    output logic [LANES-1:0]       disp_err,
    output logic                   rd_cur,
    output logic [ERRCNT_W-1:0]    err_count
);

    localparam int CW    = WIDTH / 2;
    localparam int PC_W  = $clog2(WIDTH + 1);   // holds 0..WIDTH without truncation
    localparam int EC_W  = $clog2(LANES + 1);   // holds 0..LANES
    localparam int SUM_W = ERRCNT_W + EC_W;

    localparam logic [PC_W-1:0]  ONES_BAL = PC_W'(CW);
    localparam logic [PC_W-1:0]  ONES_HI  = PC_W'(CW + 1);
    localparam logic [PC_W-1:0]  ONES_LO  = PC_W'(CW - 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = {{EC_W{1'b0}}, {ERRCNT_W{1'b1}}};

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_e;

    // Number of ones in one symbol.
    function automatic logic [PC_W-1:0] sym_ones(input logic [WIDTH-1:0] sym);
        logic [PC_W-1:0] n;
        n = '0;
        for (int b = 0; b < WIDTH; b++) n = n + PC_W'(sym[b]);
        return n;
    endfunction

    // Number of lanes that flagged an error this beat.
    function automatic logic [EC_W-1:0] err_ones(input logic [LANES-1:0] e);
        logic [EC_W-1:0] n;
        n = '0;
        for (int k = 0; k < LANES; k++) n = n + EC_W'(e[k]);
        return n;
    endfunction

    rd_e                  rd_cur_q, rd_cur_d;
    logic                 pushout_q, pushout_d;
    logic [LANES-1:0]     rd_vec_q, rd_vec_d;
    logic [LANES-1:0]     disp_err_q, disp_err_d;
    logic [ERRCNT_W-1:0]  err_count_q, err_count_d;

    logic [LANES-1:0]     rd_out;
    logic [LANES-1:0]     lane_err;
    logic [SUM_W-1:0]     err_sum;

    // Lane chain: judge each symbol against the RD left by the previous lane.
    always_comb begin
        logic            rd_in;
        logic [PC_W-1:0] ones;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_out   = '0;
        lane_err = '0;
        rd_in    = startin ? RD_NEG : rd_cur_q;
        for (int k = 0; k < LANES; k++) begin
            ones = sym_ones(datain[k*WIDTH +: WIDTH]);
            if (ones == ONES_BAL) begin
                rd_out[k] = rd_in;
            end else if (!rd_in && ones == ONES_HI) begin
                rd_out[k] = RD_POS;
            end else if (rd_in && ones == ONES_LO) begin
                rd_out[k] = RD_NEG;
            end else begin
                // Illegal disparity: recover towards the side the symbol leans.
                lane_err[k] = 1'b1;
                rd_out[k]   = (ones > ONES_BAL);
            end
            rd_in = rd_out[k];
        end
    end

    // Next-state for the RD state bit, the beat outputs and the error counter.
    always_comb begin
        pushout_d   = pushin;
        disp_err_d  = pushin ? lane_err : '0;
        rd_vec_d    = pushin ? rd_out : rd_vec_q;
        rd_cur_d    = rd_cur_q;
        err_sum     = {{EC_W{1'b0}}, err_count_q} + {{ERRCNT_W{1'b0}}, err_ones(lane_err)};
        err_count_d = err_count_q;

        if (pushin) begin
            rd_cur_d = rd_e'(rd_out[LANES-1]);
        end else if (startin) begin
            rd_cur_d = RD_NEG;
        end

        if (err_clr) begin
            err_count_d = '0;
        end else if (pushin) begin
            err_count_d = (err_sum > CNT_MAX) ? '1 : err_sum[ERRCNT_W-1:0];
        end
    end

    // State and output registers; synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            rd_cur_q    <= RD_NEG;
            pushout_q   <= 1'b0;
            rd_vec_q    <= '0;
            disp_err_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_cur_q    <= rd_cur_d;
            pushout_q   <= pushout_d;
            rd_vec_q    <= rd_vec_d;
            disp_err_q  <= disp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign pushout   = pushout_q;
    assign rd_vec    = rd_vec_q;
    assign disp_err  = disp_err_q;
    assign rd_cur    = rd_cur_q;
    assign err_count = err_count_q;

endmodule
